ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter and access sequencer in front of the single-port-per-direction data RAM. It shares the RAM between the instruction-fetch port (word reads only) and the load/store port (byte/half/word, signed/unsigned, read or write). It rejects accesses the RAM cannot serve, and returns each response through a valid/ready handshake. It sits between the core's fetch/LSU stages and the RAM instance.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on all ports.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  ADDR_W  fetch byte address.
- i_rsp_valid  out  1  fetch response valid.
- i_rsp_ready  in  1  fetch response consumed.
- i_rsp_data  out  32  fetched word.
- i_rsp_err  out  1  misaligned fetch; data is 0.
- d_req_valid  in  1  LSU request valid.
- d_req_ready  out  1  LSU request accepted this cycle.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  ADDR_W  LSU byte address.
- d_req_wdata  in  32  store data, right-aligned.
- d_req_mode  in  2  0 byte, 1 half, 2 word; 3 illegal.
- d_req_signed  in  1  load sign extension.
- d_rsp_valid  out  1  LSU response valid; loads and stores both respond.
- d_rsp_ready  in  1  LSU response consumed.
- d_rsp_rdata  out  32  load result; 0 for stores and errors.
- d_rsp_err  out  1  illegal or misaligned access.
- ram_we, ram_r_addr, ram_w_addr, ram_w_data, ram_write_mode, ram_read_mode, ram_read_signed  out  1/32/32/32/2/2/1  RAM control, with RAM mode encoding.
- ram_r_data  in  32  RAM read data, already extended by the RAM; valid after the falling edge of the ACCESS cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrate between valid requesters and assert ready combinationally for the winner only.
  - On handshake, latch addr, we, wdata, mode, signed and the owner.
  - Legal request: go to ACCESS. Illegal request: go to RESP with err=1, and the RAM is never driven.
- Legality:
  - Mode 3 is illegal.
  - Half access at addr[1:0]=3 is illegal.
  - Word access at addr[1:0]≠0 is illegal.
  - Fetch is always word mode.
- ACCESS (exactly one cycle):
  - ram_r_addr and ram_w_addr are the latched address; modes and signed are the latched values.
  - ram_we = latched we.
  - At the rising edge ending ACCESS, capture ram_r_data (loads/fetch) or 0 (stores), then go to RESP.
- RESP:
  - The owner's rsp_valid=1 and data is held stable until rsp_ready. Then go to IDLE.
  - The non-owner's rsp_valid stays 0.
- Outside ACCESS: ram_we=0; address, data and mode outputs hold their last latched values.
- No new request is accepted outside IDLE. At most one transaction is in flight.

## Timing
- Reset (async assert): state IDLE, all valid/ready outputs 0, ram_we 0, rsp data/err 0, RAM address/data/mode outputs 0, round-robin pointer = fetch (LSU wins first tie).
- Reset asserted during ACCESS drops ram_we immediately. The write is aborted if reset occurs before the falling edge.
- Legal request latency: accept edge E0 → ACCESS cycle → rsp_valid from E2. Minimum 3 cycles per transaction with rsp_ready held high.
- Illegal request: rsp_valid from E1 (one cycle earlier).
- Store takes effect at the falling edge within ACCESS. A following load of the same address returns the new data.
- rsp_ready held low: remain in RESP indefinitely. Both req_ready stay 0.

## Configuration
- RAM_ARB_RR_EN defined: round-robin. On simultaneous valid requests, grant the requester not granted last. The pointer updates on every accepted request.
- RAM_ARB_RR_EN undefined: fixed priority, LSU always wins. Fetch is served only when d_req_valid=0.

## Test plan
- Fetch of word at 0x0000_0010 (RAM holds 0xDEADBEEF) → i_req_ready at E0; i_rsp_valid at E2 with data 0xDEADBEEF, err 0.
- LSU store byte 0xA5 at 0x21, then signed byte load at 0x21 → second response d_rsp_rdata 0xFFFF_FFA5. Unsigned load returns 0x0000_00A5; other bytes of word 0x20 unchanged.
- LSU half load at 0x23, word at 0x22, mode 3 at 0x20 → each d_rsp_err=1, rdata 0, ram_we never 1, rsp_valid one cycle after accept.
- Both valid every cycle, rsp_ready=1: with RAM_ARB_RR_EN, grants alternate LSU, fetch, LSU…; without it, LSU granted every transaction.
- Hold d_rsp_ready=0 for 5 cycles with fetch pending → d_rsp_valid and data stable, i_req_ready 0 throughout; fetch accepted the cycle after the IDLE return.
- Assert rst_n=0 mid-ACCESS of a word store to 0x40 before the falling edge → ram_we drops immediately, mem[0x40] unchanged, all outputs at reset values.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one data RAM between the instruction-fetch port
// (word reads) and the load/store port (byte/half/word, read or write).
// Each transaction goes IDLE -> ACCESS -> RESP, or IDLE -> RESP when the
// request cannot be served.
// Optional feature macro: RAM_ARB_RR_EN. When it is defined, simultaneous
// requests are granted round-robin. When it is undefined, the LSU always wins.
module ram_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction-fetch request / response
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       i_rsp_data,
  output logic              i_rsp_err,
  // Load/store request / response
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  input  logic [1:0]        d_req_mode,
  input  logic              d_req_signed,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [31:0]       d_rsp_rdata,
  output logic              d_rsp_err,
  // RAM side
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [31:0]       ram_w_data,
  output logic [1:0]        ram_write_mode,
  output logic [1:0]        ram_read_mode,
  output logic              ram_read_signed,
  input  logic [31:0]       ram_r_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_WORD = 2'd2;

  state_e            state_q;
  logic              owner_lsu_q;   // 1: LSU owns the transaction, 0: fetch

  // RAM control registers; they keep their last legal values between accesses
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;
  logic [1:0]        ram_mode_q;
  logic              ram_signed_q;

  // Response registers per port
  logic              i_rsp_valid_q;
  logic [31:0]       i_rsp_data_q;
  logic              i_rsp_err_q;
  logic              d_rsp_valid_q;
  logic [31:0]       d_rsp_rdata_q;
  logic              d_rsp_err_q;

  // Arbitration and the selected (winning) request
  logic              grant_i;
  logic              grant_d;
  logic              any_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_mode;
  logic              sel_signed;
  logic              sel_legal;
  logic              rsp_ack;
  logic [31:0]       access_data;

  // An access is legal when the RAM can serve it inside one aligned word.
  // A half access at offset 1 stays within the word, so it is allowed.
  function automatic logic access_legal(input logic [1:0] mode, input logic [1:0] off);
    logic ok;
    case (mode)
      MODE_BYTE: ok = 1'b1;
      MODE_HALF: ok = (off != 2'd3);
      MODE_WORD: ok = (off == 2'd0);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef RAM_ARB_RR_EN
  logic last_lsu_q;   // 1: LSU was granted last; reset value makes LSU win the first tie
  logic last_lsu_d;

  // Round-robin grant: on a tie, serve whichever port was not granted last
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req_valid && d_req_valid) begin
        grant_d = ~last_lsu_q;
        grant_i = last_lsu_q;
      end else begin
        grant_d = d_req_valid;
        grant_i = i_req_valid;
      end
    end
  end

  // The pointer follows every accepted request
  always_comb begin
    last_lsu_d = last_lsu_q;
    if (grant_d) begin
      last_lsu_d = 1'b1;
    end else if (grant_i) begin
      last_lsu_d = 1'b0;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu_q <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
`else
  // Fixed priority: the LSU always wins, fetch only when the LSU is quiet
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      grant_d = d_req_valid;
      grant_i = i_req_valid & ~d_req_valid;
    end
  end
`endif

  // Route the winning request; fetch is always an unsigned word read
  always_comb begin
    any_grant  = grant_i | grant_d;
    sel_addr   = grant_d ? d_req_addr : i_req_addr;
    sel_we     = grant_d & d_req_we;
    sel_wdata  = grant_d ? d_req_wdata : 32'd0;
    sel_mode   = grant_d ? d_req_mode : MODE_WORD;
    sel_signed = grant_d & d_req_signed;
    sel_legal  = access_legal(sel_mode, sel_addr[1:0]);
  end

  // Response handshake of the current owner, and the data captured at the end of ACCESS
  always_comb begin
    rsp_ack     = owner_lsu_q ? d_rsp_ready : i_rsp_ready;
    access_data = ram_we_q ? 32'd0 : ram_r_data;
  end

  // Main sequencer: the state, the RAM controls and the responses are all registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_lsu_q   <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= 32'd0;
      ram_mode_q    <= MODE_BYTE;
      ram_signed_q  <= 1'b0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= 32'd0;
      i_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_rdata_q <= 32'd0;
      d_rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_grant) begin
            owner_lsu_q <= grant_d;
            if (sel_legal) begin
              ram_we_q     <= sel_we;
              ram_addr_q   <= sel_addr;
              ram_wdata_q  <= sel_wdata;
              ram_mode_q   <= sel_mode;
              ram_signed_q <= sel_signed;
              state_q      <= ACCESS;
            end else begin
              // A rejected request never touches the RAM and answers at once
              if (grant_d) begin
                d_rsp_valid_q <= 1'b1;
                d_rsp_rdata_q <= 32'd0;
                d_rsp_err_q   <= 1'b1;
              end else begin
                i_rsp_valid_q <= 1'b1;
                i_rsp_data_q  <= 32'd0;
                i_rsp_err_q   <= 1'b1;
              end
              state_q <= RESP;
            end
          end
        end
        ACCESS: begin
          // The RAM has produced the read data (or finished the write) by the falling edge
          ram_we_q <= 1'b0;
          if (owner_lsu_q) begin
            d_rsp_valid_q <= 1'b1;
            d_rsp_rdata_q <= access_data;
            d_rsp_err_q   <= 1'b0;
          end else begin
            i_rsp_valid_q <= 1'b1;
            i_rsp_data_q  <= access_data;
            i_rsp_err_q   <= 1'b0;
          end
          state_q <= RESP;
        end
        RESP: begin
          // Hold the response until the owner takes it
          if (rsp_ack) begin
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_req_ready     = grant_i;
  assign d_req_ready     = grant_d;

  assign i_rsp_valid     = i_rsp_valid_q;
  assign i_rsp_data      = i_rsp_data_q;
  assign i_rsp_err       = i_rsp_err_q;
  assign d_rsp_valid     = d_rsp_valid_q;
  assign d_rsp_rdata     = d_rsp_rdata_q;
  assign d_rsp_err       = d_rsp_err_q;

  assign ram_we          = ram_we_q;
  assign ram_r_addr      = ram_addr_q;
  assign ram_w_addr      = ram_addr_q;
  assign ram_w_data      = ram_wdata_q;
  assign ram_write_mode  = ram_mode_q;
  assign ram_read_mode   = ram_mode_q;
  assign ram_read_signed = ram_signed_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural RAM model.
// The RAM writes and updates its read data on the falling clock edge.
// Build with RAM_ARB_RR_EN defined to exercise the round-robin arbiter.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid, i_rsp_ready, i_rsp_err;
  logic [31:0] i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_req_signed;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [1:0]  d_req_mode;
  logic        d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic        ram_we, ram_read_signed;
  logic [31:0] ram_r_addr, ram_w_addr, ram_w_data, ram_r_data;
  logic [1:0]  ram_write_mode, ram_read_mode;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  ram_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_mode(d_req_mode),
    .d_req_signed(d_req_signed),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
    .d_rsp_err(d_rsp_err),
    .ram_we(ram_we), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_write_mode(ram_write_mode),
    .ram_read_mode(ram_read_mode), .ram_read_signed(ram_read_signed),
    .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // RAM read with extension, as the real RAM delivers it
  function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [1:0] m, input logic s);
    logic [31:0] sh;
    logic [31:0] r;
    sh = mem[a[9:2]] >> {a[1:0], 3'b000};
    case (m)
      2'd0:    r = s ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      2'd1:    r = s ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // RAM model: write and read both take effect on the falling edge
  always @(negedge clk) begin
    logic [31:0] msk;
    if (ram_we) begin
      msk = (ram_write_mode == 2'd0) ? 32'h0000_00FF :
            (ram_write_mode == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      msk = msk << {ram_w_addr[1:0], 3'b000};
      mem[ram_w_addr[9:2]] = (mem[ram_w_addr[9:2]] & ~msk) |
                             ((ram_w_data << {ram_w_addr[1:0], 3'b000}) & msk);
    end
    ram_r_data <= ram_read(ram_r_addr, ram_read_mode, ram_read_signed);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One LSU transaction with immediate response acceptance
  task automatic lsu(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] mode, input logic sgn,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic we_seen, output logic i_seen);
    logic ok;
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr;
    d_req_wdata = wdata; d_req_mode = mode; d_req_signed = sgn;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (d_req_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    chk("d_req_accepted", {31'd0, ok}, 32'd1);
    d_req_valid = 1'b0;
    we_seen = 1'b0; i_seen = 1'b0; lat = 1; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      we_seen |= ram_we;
      i_seen  |= i_rsp_valid;
      if (d_rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    chk("d_rsp_seen", {31'd0, ok}, 32'd1);
    rdata = d_rsp_rdata;
    err   = d_rsp_err;
    d_rsp_ready = 1'b1;
    tick();
    d_rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er, wes, is;
    int          lat, ng;
    logic [3:0]  gr;
    logic        ok;

    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    mem[32'h10 >> 2] = 32'hDEAD_BEEF;
    mem[32'h20 >> 2] = 32'h1122_3344;
    mem[32'h40 >> 2] = 32'hCAFE_F00D;

    rst_n = 1'b0;
    i_req_valid = 0; i_req_addr = 0; i_rsp_ready = 0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0;
    d_req_mode = 0; d_req_signed = 0; d_rsp_ready = 0;

    // Reset state
    #12;
    chk("rst_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
    chk("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_r_addr", ram_r_addr, 32'd0);
    chk("rst_d_rsp_rdata", d_rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Fetch of word 0x10: ready in cycle E0, response from E2
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    #1;
    chk("fetch_ready_e0", {31'd0, i_req_ready}, 32'd1);
    chk("fetch_d_ready_0", {31'd0, d_req_ready}, 32'd0);
    tick();
    i_req_valid = 1'b0;
    chk("fetch_access_addr", ram_r_addr, 32'h10);
    chk("fetch_access_mode", {30'd0, ram_read_mode}, 32'd2);
    chk("fetch_access_we", {31'd0, ram_we}, 32'd0);
    chk("fetch_valid_e1", {31'd0, i_rsp_valid}, 32'd0);
    tick();
    chk("fetch_valid_e2", {31'd0, i_rsp_valid}, 32'd1);
    chk("fetch_data", i_rsp_data, 32'hDEAD_BEEF);
    chk("fetch_err", {31'd0, i_rsp_err}, 32'd0);
    chk("fetch_d_valid_0", {31'd0, d_rsp_valid}, 32'd0);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("fetch_valid_drop", {31'd0, i_rsp_valid}, 32'd0);
    $display("fetch 0x10 -> %h err %0d", 32'hDEAD_BEEF, 0);

    // Store byte 0xA5 at 0x21
    lsu(1'b1, 32'h21, 32'h0000_00A5, 2'd0, 1'b0, rd, er, lat, wes, is);
    $display("store byte 0x21 rdata %h err %0d lat %0d", rd, er, lat);
    chk("sb_rdata", rd, 32'd0);
    chk("sb_err", {31'd0, er}, 32'd0);
    chk("sb_lat", lat, 32'd2);
    chk("sb_we_seen", {31'd0, wes}, 32'd1);
    chk("sb_no_fetch_rsp", {31'd0, is}, 32'd0);
    chk("sb_mem", mem[32'h20 >> 2], 32'h1122_A544);

    // Signed byte load at 0x21
    lsu(1'b0, 32'h21, 32'd0, 2'd0, 1'b1, rd, er, lat, wes, is);
    $display("load sbyte 0x21 rdata %h err %0d lat %0d", rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFF_FFA5);
    chk("lb_we_seen", {31'd0, wes}, 32'd0);

    // Unsigned byte load at 0x21
    lsu(1'b0, 32'h21, 32'd0, 2'd0, 1'b0, rd, er, lat, wes, is);
    $display("load ubyte 0x21 rdata %h err %0d lat %0d", rd, er, lat);
    chk("lbu_rdata", rd, 32'h0000_00A5);

    // Word load at 0x20: other bytes untouched
    lsu(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, rd, er, lat, wes, is);
    $display("load word 0x20 rdata %h err %0d lat %0d", rd, er, lat);
    chk("lw_rdata", rd, 32'h1122_A544);

    // Signed half load at offset 1 is legal and stays inside the word
    lsu(1'b0, 32'h21, 32'd0, 2'd1, 1'b1, rd, er, lat, wes, is);
    $display("load shalf 0x21 rdata %h err %0d lat %0d", rd, er, lat);
    chk("lh1_rdata", rd, 32'h0000_22A5);
    chk("lh1_err", {31'd0, er}, 32'd0);

    // Illegal: half at 0x23 (store, so a wrongly driven RAM would show)
    lsu(1'b1, 32'h23, 32'h0000_BEEF, 2'd1, 1'b0, rd, er, lat, wes, is);
    $display("store half 0x23 rdata %h err %0d lat %0d", rd, er, lat);
    chk("ill_h_err", {31'd0, er}, 32'd1);
    chk("ill_h_rdata", rd, 32'd0);
    chk("ill_h_lat", lat, 32'd1);
    chk("ill_h_we", {31'd0, wes}, 32'd0);

    // Illegal: word at 0x22
    lsu(1'b0, 32'h22, 32'd0, 2'd2, 1'b0, rd, er, lat, wes, is);
    $display("load word 0x22 rdata %h err %0d lat %0d", rd, er, lat);
    chk("ill_w_err", {31'd0, er}, 32'd1);
    chk("ill_w_rdata", rd, 32'd0);
    chk("ill_w_lat", lat, 32'd1);

    // Illegal: mode 3 at 0x20 (store)
    lsu(1'b1, 32'h20, 32'hFFFF_FFFF, 2'd3, 1'b0, rd, er, lat, wes, is);
    $display("store mode3 0x20 rdata %h err %0d lat %0d", rd, er, lat);
    chk("ill_m3_err", {31'd0, er}, 32'd1);
    chk("ill_m3_rdata", rd, 32'd0);
    chk("ill_m3_lat", lat, 32'd1);
    chk("ill_m3_we", {31'd0, wes}, 32'd0);
    chk("ill_mem", mem[32'h20 >> 2], 32'h1122_A544);

    // Reset pulse between transactions so the arbiter pointer starts fresh
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_ram_w_addr", ram_w_addr, 32'd0);
    chk("rst2_mode", {30'd0, ram_write_mode}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Both requesters valid every cycle, responses taken immediately
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h20;
    d_req_mode = 2'd2; d_req_signed = 1'b0;
    i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    #1;
    gr = 4'd0; ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      if (d_req_ready || i_req_ready) begin
        chk("arb_onehot", {31'd0, d_req_ready & i_req_ready}, 32'd0);
        gr[ng] = d_req_ready;
        $display("arb grant %0d -> %s", ng, d_req_ready ? "LSU" : "FETCH");
        ng++;
      end
      tick();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    chk("arb_count", ng, 32'd4);
`ifdef RAM_ARB_RR_EN
    chk("arb_pattern", {28'd0, gr}, 32'h5);
`else
    chk("arb_pattern", {28'd0, gr}, 32'hF);
`endif
    tick(); tick(); tick();
    i_rsp_ready = 1'b0; d_rsp_ready = 1'b0;

    // LSU response stalled for 5 cycles with a fetch pending
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h20; d_req_mode = 2'd2;
    #1;
    chk("stall_d_ready", {31'd0, d_req_ready}, 32'd1);
    chk("stall_i_ready0", {31'd0, i_req_ready}, 32'd0);
    tick();
    d_req_valid = 1'b0;
    chk("stall_access_i_ready", {31'd0, i_req_ready}, 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_d_valid", {31'd0, d_rsp_valid}, 32'd1);
      chk("stall_d_rdata", d_rsp_rdata, 32'h1122_A544);
      chk("stall_i_ready", {31'd0, i_req_ready}, 32'd0);
      tick();
    end
    $display("stall held d_rsp %h for 5 cycles", d_rsp_rdata);
    d_rsp_ready = 1'b1;
    #1;
    chk("stall_release_valid", {31'd0, d_rsp_valid}, 32'd1);
    tick();
    d_rsp_ready = 1'b0;
    chk("stall_idle_d_valid", {31'd0, d_rsp_valid}, 32'd0);
    chk("stall_idle_i_ready", {31'd0, i_req_ready}, 32'd1);
    tick();
    i_req_valid = 1'b0;
    tick();
    chk("stall_fetch_valid", {31'd0, i_rsp_valid}, 32'd1);
    chk("stall_fetch_data", i_rsp_data, 32'hDEAD_BEEF);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;

    // Reset during ACCESS of a word store to 0x40, before the falling edge
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h40;
    d_req_wdata = 32'h1234_5678; d_req_mode = 2'd2;
    #1;
    ok = d_req_ready;
    chk("rstacc_ready", {31'd0, ok}, 32'd1);
    tick();
    d_req_valid = 1'b0;
    chk("rstacc_we_before", {31'd0, ram_we}, 32'd1);
    chk("rstacc_w_addr", ram_w_addr, 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstacc_we_drop", {31'd0, ram_we}, 32'd0);
    chk("rstacc_d_valid", {31'd0, d_rsp_valid}, 32'd0);
    chk("rstacc_d_ready", {31'd0, d_req_ready}, 32'd0);
    chk("rstacc_w_addr0", ram_w_addr, 32'd0);
    chk("rstacc_w_data0", ram_w_data, 32'd0);
    #6;
    chk("rstacc_mem", mem[32'h40 >> 2], 32'hCAFE_F00D);
    $display("reset mid-access mem[0x40] %h", mem[32'h40 >> 2]);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
